// File: rtl/alu_seq.sv
// Sequencer that issues one instruction at a time to an external registered ALU and writes the result back to a 4x8 register file.
// Define ALU_SEQ_IMM_EN to let in_imm_sel/in_imm supply operand B; otherwise B always comes from the register file.
//
// state | meaning
// IDLE  | ready for an instruction
// ISSUE | operands and opcode presented to the ALU
// EXEC  | ALU result register loading
// WB    | retire: done pulse, result written back unless illegal
module alu_seq (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [1:0] in_dst,
  input  logic [1:0] in_src1,
  input  logic [1:0] in_src2,
  input  logic       in_imm_sel,
  input  logic [7:0] in_imm,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [3:0] CTR,
  input  logic [7:0] O,
  output logic       done,
  output logic       err,
  output logic       zero,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  logic [1:0] state;
  logic [1:0] dst;
  logic       ill;
  logic [7:0] rf [4];
  logic       accept;
  logic       legal;
  logic [7:0] b_next;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign legal    = (in_op == 4'd0) || (in_op == 4'd1) || (in_op >= 4'd9);
  assign rd_data  = rf[rd_addr];

`ifdef ALU_SEQ_IMM_EN
  assign b_next = in_imm_sel ? in_imm : rf[in_src2];
`else
  logic unused_imm;
  assign unused_imm = ^{in_imm_sel, in_imm};
  assign b_next     = rf[in_src2];
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dst   <= 2'd0;
      ill   <= 1'b0;
      A     <= 8'd0;
      B     <= 8'd0;
      CTR   <= 4'd0;
      done  <= 1'b0;
      err   <= 1'b0;
      zero  <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dst <= in_dst;
            if (legal) begin
              A     <= rf[in_src1];
              B     <= b_next;
              CTR   <= in_op;
              ill   <= 1'b0;
              state <= ISSUE;
            end else begin
              // Illegal ops skip the ALU entirely and retire on the next cycle.
              ill   <= 1'b1;
              done  <= 1'b1;
              err   <= 1'b1;
              state <= WB;
            end
          end
        end
        ISSUE: state <= EXEC;
        EXEC: begin
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (!ill) begin
            rf[dst] <= O;
            zero    <= (O == 8'h00);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a bench-side registered ALU, a cycle model of the sequencer's observable behaviour,
// and literal checks on the values the instruction sequences must produce.
module tb_alu_seq;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_dst, in_src1, in_src2;
  logic       in_imm_sel;
  logic [7:0] in_imm;
  logic [7:0] A, B;
  logic [3:0] CTR;
  logic [7:0] O;
  logic       done, err, zero;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;

`ifdef ALU_SEQ_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  int nchk  = 0;
  int nfail = 0;

  alu_seq dut (
    .ck(ck), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .A(A), .B(B), .CTR(CTR), .O(O),
    .done(done), .err(err), .zero(zero),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 ck = ~ck;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd9:    return a & b;
      4'd10:   return a ^ b;
      4'd11:   return a | b;
      4'd12:   return ~a;
      4'd13:   return a << 1;
      4'd14:   return {a[0], a[7:1]};
      4'd15:   return a + 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  // External ALU: result registered on every edge from the presented operands.
  logic [7:0] o_alu = 8'd0;
  always @(posedge ck) o_alu <= alu_f(CTR, A, B);
  assign O = o_alu;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cnt = cycles until the sequencer is idle again (3 after a legal accept, 1 after an illegal one).
  logic [7:0] m_rf [4];
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_ctr;
  logic [1:0] m_dst;
  logic       m_ill, m_zero, seen_rst = 1'b0;
  int         cnt;

  always @(negedge ck) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
      m_a = 0; m_b = 0; m_ctr = 0; m_zero = 0; m_ill = 0; cnt = 0;
      seen_rst = 1'b1;
    end
    if (seen_rst) begin
      chk("in_ready", {7'd0, in_ready}, {7'd0, cnt == 0});
      chk("done", {7'd0, done}, {7'd0, cnt == 1});
      chk("err", {7'd0, err}, {7'd0, cnt == 1 && m_ill});
      chk("A", A, m_a);
      chk("B", B, m_b);
      chk("CTR", {4'd0, CTR}, {4'd0, m_ctr});
      chk("zero", {7'd0, zero}, {7'd0, m_zero});
      chk("rd_data", rd_data, m_rf[rd_addr]);
    end
    if (rst_n && seen_rst) begin
      if (cnt == 0) begin
        if (in_valid) begin
          m_dst = in_dst;
          if (in_op == 4'd0 || in_op == 4'd1 || in_op >= 4'd9) begin
            m_a   = m_rf[in_src1];
            m_b   = (IMM && in_imm_sel) ? in_imm : m_rf[in_src2];
            m_ctr = in_op;
            m_res = alu_f(m_ctr, m_a, m_b);
            m_ill = 1'b0;
            cnt   = 3;
          end else begin
            m_ill = 1'b1;
            cnt   = 1;
          end
        end
      end else if (cnt == 1) begin
        if (!m_ill) begin
          m_rf[m_dst] = m_res;
          m_zero      = (m_res == 8'h00);
        end
        cnt = 0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2,
                       input logic sel, input logic [7:0] imm, input int exp_lat);
    int waited, lat;
    logic err_seen;
    @(posedge ck); #1;
    in_op = op; in_dst = d; in_src1 = s1; in_src2 = s2; in_imm_sel = sel; in_imm = imm;
    in_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge ck);
      waited++;
    end while (!in_ready && waited < 20);
    if (!in_ready) chk("ready_timeout", 8'd0, 8'd1);
    @(posedge ck); #1;
    in_valid = 1'b0;
    lat = 0;
    err_seen = 1'b0;
    do begin
      @(negedge ck);
      lat++;
      err_seen = err;
    end while (!done && lat < 10);
    chk("latency", lat[7:0], exp_lat[7:0]);
    chk("err_at_done", {7'd0, err_seen}, {7'd0, exp_lat == 1});
  endtask

  task automatic peek(input logic [1:0] a, input logic [7:0] exp);
    @(posedge ck); #2;
    rd_addr = a;
    #1;
    chk("rf_literal", rd_data, exp);
  endtask

  int readies, dones;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_op = 0; in_dst = 0; in_src1 = 0; in_src2 = 0;
    in_imm_sel = 0; in_imm = 0; rd_addr = 0;
    repeat (3) @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[1:0]; #1;
      chk("reset_rf", rd_data, 8'h00);
    end
    chk("reset_A", A, 8'h00);
    chk("reset_B", B, 8'h00);
    chk("reset_CTR", {4'd0, CTR}, 8'h00);
    chk("reset_ready", {7'd0, in_ready}, 8'd1);
    chk("reset_done", {7'd0, done}, 8'd0);
    @(posedge ck); #1;
    rst_n = 1'b1;

    if (IMM) begin
      issue(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 3);
      issue(4'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h03, 3);
    end else begin
      issue(4'd15, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 3);
      issue(4'd15, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 3);
      issue(4'd0, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, 3);
      issue(4'd15, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 3);
      issue(4'd0, 2'd0, 2'd1, 2'd2, 1'b1, 8'h40, 3);
      chk("B_ignores_imm", B, 8'h02);
    end
    peek(2'd0, 8'h05);
    peek(2'd1, 8'h03);

    issue(4'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 3);
    peek(2'd2, 8'h02);
    chk("zero_after_sub", {7'd0, zero}, 8'd0);

    issue(4'd10, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 3);
    peek(2'd3, 8'h00);
    chk("zero_after_xor", {7'd0, zero}, 8'd1);

    issue(4'd14, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 3);
    peek(2'd1, 8'h82);
    issue(4'd13, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 3);
    peek(2'd1, 8'h04);
    chk("zero_after_shl", {7'd0, zero}, 8'd0);

    issue(4'd4, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, 1);
    chk("illegal_CTR_held", {4'd0, CTR}, 8'h0D);
    peek(2'd0, 8'h05);
    chk("illegal_zero_held", {7'd0, zero}, 8'd0);

    // Back-to-back: in_valid held high for four full instruction slots.
    readies = 0; dones = 0;
    @(posedge ck); #1;
    in_op = 4'd15; in_dst = 2'd3; in_src1 = 2'd3; in_src2 = 2'd0; in_imm_sel = 0; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge ck);
      if (in_ready) readies++;
      if (done) dones++;
    end
    @(posedge ck); #1;
    in_valid = 1'b0;
    chk("b2b_readies", readies[7:0], 8'd4);
    chk("b2b_dones", dones[7:0], 8'd4);
    peek(2'd3, 8'h04);

    // Reset while op 0000 on r0 is in EXEC.
    @(posedge ck); #1;
    in_op = 4'd0; in_dst = 2'd0; in_src1 = 2'd0; in_src2 = 2'd0; in_imm_sel = 1'b1; in_imm = 8'h11;
    in_valid = 1'b1;
    @(negedge ck);
    chk("pre_abort_ready", {7'd0, in_ready}, 8'd1);
    @(posedge ck); #1;
    in_valid = 1'b0;
    @(posedge ck); #1;
    rst_n = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge ck);
      if (done) dones++;
    end
    chk("abort_no_done", dones[7:0], 8'd0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = i[1:0]; #1;
      chk("abort_rf", rd_data, 8'h00);
    end
    chk("abort_ready", {7'd0, in_ready}, 8'd1);
    chk("abort_A", A, 8'h00);
    @(posedge ck); #1;
    rst_n = 1'b1;
    issue(4'd15, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 3);
    peek(2'd1, 8'h01);

    repeat (3) @(negedge ck);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
